// File: rtl/algo_16m8d_ma_pkg.sv
// Shared definitions for the 16m8d malloc prefetch client.
//   state_e    : controller states (WAIT_RDY / ACTIVE / FLUSH)
//   ErrCntSat  : saturation value of the optional ECC event counters
//   cnt_width  : width of the FIFO / outstanding counters for a given log2 depth
package algo_16m8d_ma_pkg;

    typedef enum logic [1:0] {
        StWaitRdy = 2'd0,
        StActive  = 2'd1,
        StFlush   = 2'd2
    } state_e;

    localparam logic [15:0] ErrCntSat = 16'hFFFF;

    // Counters must represent the full depth, hence one bit more than log2(depth).
    function automatic int unsigned cnt_width(input int unsigned bitfifo);
        return bitfifo + 1;
    endfunction

endpackage

// File: rtl/algo_16m8d_ma_prefetch_if.sv
// Allocator-side bus of the malloc prefetch client.
//   ready                    : allocator free list initialised
//   ma_write                 : malloc request, one pulse per address
//   ma_vld/ma_adr            : in-order malloc response
//   ma_bp                    : allocator backpressure
//   ma_serr/ma_derr          : corrected / uncorrectable error on the response
//   dq_vld/dq_adr            : address returned to the free list
// Modports: master = prefetch client, slave = allocator.
interface algo_16m8d_ma_prefetch_if #(
    parameter int unsigned BITADDR = 14
);
    logic               ready;
    logic               ma_write;
    logic               ma_vld;
    logic [BITADDR-1:0] ma_adr;
    logic               ma_bp;
    logic               ma_serr;
    logic               ma_derr;
    logic               dq_vld;
    logic [BITADDR-1:0] dq_adr;

    modport master (
        input  ready, ma_vld, ma_adr, ma_bp, ma_serr, ma_derr,
        output ma_write, dq_vld, dq_adr
    );

    modport slave (
        output ready, ma_vld, ma_adr, ma_bp, ma_serr, ma_derr,
        input  ma_write, dq_vld, dq_adr
    );

endinterface

// File: rtl/algo_16m8d_ma_fifo.sv
// Register FIFO holding prefetched allocator addresses.
//   clk, rst (async, active-low)
//   push/push_adr : write an address (ignored when full)
//   pop           : drop the head (ignored when empty)
//   clear         : discard all contents, wins over push/pop
//   head          : oldest entry
//   count         : number of valid entries (BITFIFO+1 bits)
// FIFODEP must equal 2**BITFIFO so the pointers wrap naturally.
module algo_16m8d_ma_fifo #(
    parameter int unsigned BITADDR = 14,
    parameter int unsigned FIFODEP = 4,
    parameter int unsigned BITFIFO = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [BITADDR-1:0] push_adr,
    input  logic               pop,
    input  logic               clear,
    output logic [BITADDR-1:0] head,
    output logic [BITFIFO:0]   count
);

    localparam logic [BITFIFO:0]   Full   = (BITFIFO + 1)'(FIFODEP);
    localparam logic [BITFIFO:0]   CntOne = (BITFIFO + 1)'(1);
    localparam logic [BITFIFO-1:0] PtrOne = BITFIFO'(1);

    logic [BITADDR-1:0] mem_q [FIFODEP];
    logic [BITFIFO-1:0] rd_ptr_q;
    logic [BITFIFO-1:0] wr_ptr_q;
    logic [BITFIFO:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && (count_q != Full);
    assign do_pop  = pop && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFODEP); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_adr;
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntOne;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntOne;
            end
        end
    end

endmodule

// File: rtl/algo_16m8d_ma_prefetch.sv
// Client-side end of the 16m8d allocator malloc/dequeue interface.
// Keeps up to FIFODEP addresses buffered or in flight, hands them to one consumer, returns
// freed addresses to the allocator, and on flush returns every held address.
// Ports:
//   clk, rst (async, active-low)
//   bus        : allocator bus (master modport): ready, ma_*, dq_*
//   al_vld/al_adr/al_pop : prefetched address to the consumer
//   fr_vld/fr_adr/fr_rdy : consumer frees an address
//   flush/flush_done     : return all held addresses; one-cycle completion pulse
//   prot_err   : sticky, response seen with nothing outstanding
// Optional feature macro ALGO_16M8D_MA_ERRCNT_EN adds saturating serr_cnt/derr_cnt outputs.
module algo_16m8d_ma_prefetch
    import algo_16m8d_ma_pkg::*;
#(
    parameter int unsigned BITADDR = 14,
    parameter int unsigned FIFODEP = 4,
    parameter int unsigned BITFIFO = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    algo_16m8d_ma_prefetch_if.master      bus,
    output logic                          al_vld,
    output logic [BITADDR-1:0]            al_adr,
    input  logic                          al_pop,
    input  logic                          fr_vld,
    input  logic [BITADDR-1:0]            fr_adr,
    output logic                          fr_rdy,
    input  logic                          flush,
    output logic                          flush_done,
    output logic                          prot_err
`ifdef ALGO_16M8D_MA_ERRCNT_EN
    ,
    output logic [15:0]                   serr_cnt,
    output logic [15:0]                   derr_cnt
`endif
);

    localparam int unsigned       CntW   = cnt_width(BITFIFO);
    localparam logic [CntW-1:0]   CntOne = CntW'(1);
    localparam logic [CntW:0]     Depth  = (CntW + 1)'(FIFODEP);

    state_e             state_q;
    logic [CntW-1:0]    ocnt_q;
    logic [CntW-1:0]    fcnt;
    logic               dq_vld_q;
    logic [BITADDR-1:0] dq_adr_q;
    logic               prot_err_q;
    logic [BITADDR-1:0] fifo_head;

    logic               is_active;
    logic               is_flush;
    logic               fifo_nempty;
    logic [CntW:0]      in_flight;
    logic               ma_write;
    logic               rsp_ok;
    logic               push;
    logic               flush_pop;
    logic               pop;
    logic               lose_rdy;

    assign is_active   = (state_q == StActive);
    assign is_flush    = (state_q == StFlush);
    assign fifo_nempty = (fcnt != '0);
    // Credit: buffered plus outstanding never exceeds the FIFO depth, so a push never overflows.
    assign in_flight   = {1'b0, fcnt} + {1'b0, ocnt_q};
    assign ma_write    = is_active && bus.ready && !bus.ma_bp && (in_flight < Depth);
    // Responses only count against an outstanding request; strays flag prot_err instead.
    assign rsp_ok      = bus.ma_vld && (ocnt_q != '0);
    assign push        = rsp_ok && !bus.ma_derr;
    // With ready low the allocator is reinitialising; held addresses are simply dropped.
    assign flush_pop   = is_flush && bus.ready && fifo_nempty;
    assign pop         = (is_active && al_pop && fifo_nempty) || flush_pop;
    assign lose_rdy    = (state_q != StWaitRdy) && !bus.ready;

    assign flush_done  = is_flush && bus.ready && !fifo_nempty && (ocnt_q == '0);
    assign al_vld      = is_active && fifo_nempty;
    assign al_adr      = fifo_head;
    assign fr_rdy      = is_active;
    assign prot_err    = prot_err_q;

    assign bus.ma_write = ma_write;
    assign bus.dq_vld   = dq_vld_q;
    assign bus.dq_adr   = dq_adr_q;

    algo_16m8d_ma_fifo #(
        .BITADDR (BITADDR),
        .FIFODEP (FIFODEP),
        .BITFIFO (BITFIFO)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_adr (bus.ma_adr),
        .pop      (pop),
        .clear    (lose_rdy),
        .head     (fifo_head),
        .count    (fcnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StWaitRdy;
            ocnt_q     <= '0;
            dq_vld_q   <= 1'b0;
            dq_adr_q   <= '0;
            prot_err_q <= 1'b0;
        end else begin
            if (bus.ma_vld && (ocnt_q == '0)) begin
                prot_err_q <= 1'b1;
            end

            // Frees only arrive in ACTIVE and flush pops only in FLUSH, so dq never collides.
            dq_vld_q <= (is_active && fr_vld) || flush_pop;
            dq_adr_q <= flush_pop ? fifo_head : fr_adr;

            if (lose_rdy) begin
                ocnt_q <= '0;
            end else if (ma_write && !rsp_ok) begin
                ocnt_q <= ocnt_q + CntOne;
            end else if (!ma_write && rsp_ok) begin
                ocnt_q <= ocnt_q - CntOne;
            end

            unique case (state_q)
                StWaitRdy: begin
                    if (bus.ready) state_q <= StActive;
                end
                StActive: begin
                    if (!bus.ready)  state_q <= StWaitRdy;
                    else if (flush)  state_q <= StFlush;
                end
                StFlush: begin
                    if (!bus.ready)      state_q <= StWaitRdy;
                    else if (flush_done) state_q <= StActive;
                end
                default: state_q <= StWaitRdy;
            endcase
        end
    end

`ifdef ALGO_16M8D_MA_ERRCNT_EN
    logic [15:0] serr_cnt_q;
    logic [15:0] derr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serr_cnt_q <= '0;
            derr_cnt_q <= '0;
        end else begin
            if (rsp_ok && bus.ma_serr && (serr_cnt_q != ErrCntSat)) begin
                serr_cnt_q <= serr_cnt_q + 16'd1;
            end
            if (rsp_ok && bus.ma_derr && (derr_cnt_q != ErrCntSat)) begin
                derr_cnt_q <= derr_cnt_q + 16'd1;
            end
        end
    end

    assign serr_cnt = serr_cnt_q;
    assign derr_cnt = derr_cnt_q;
`else
    logic unused_serr;
    assign unused_serr = bus.ma_serr;
`endif

endmodule
